// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants and inverter state encoding.
// Combinational definitions only: no latency, no flow control.
// Imported by the field multiplier, the inverter and the point-arithmetic units.
package secp256k1_pkg;

   localparam logic [255:0] P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ITER
   } inv_state_t;

endpackage

// File: rtl/mod_sub_p.sv
// Modular subtract (x - y) mod P for operands already reduced below P.
// Purely combinational: zero latency, no backpressure.
// Instantiated once per update path that needs a modular subtract.
module mod_sub_p
   import secp256k1_pkg::*;
(
   input  logic [255:0] x,
   input  logic [255:0] y,
   output logic [255:0] d
);

   // When x < y the true value x + P - y is still below P, so 256-bit wraparound is exact.
   assign d = (x >= y) ? (x - y) : (x - y + P);

endmodule

// File: rtl/mod_inv.sv
// secp256k1 modular inverter: result = a^-1 mod P via binary extended Euclid, one step per cycle.
// Latency data-dependent: done at E1 for a = 0 mod P, E2 at best, no later than E1 + 1026.
// start is sampled only in IDLE; done holds until the next accepted start.
module mod_inv
   import secp256k1_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] a,
   output logic [255:0] result,
   output logic         done,
   output logic         busy,
   output logic         err
);

   inv_state_t   state, state_nxt;
   logic [255:0] u, v, x1, x2;
   logic [255:0] u_nxt, v_nxt, x1_nxt, x2_nxt, result_nxt;
   logic         done_nxt, err_nxt;
   logic [255:0] u_red, x1_sub, x2_sub;

   // x is odd and below P, so x + P is even; forming it in 257 bits keeps the carry.
   function automatic logic [255:0] halve(input logic [255:0] x);
      if (x[0])
         return 256'(({1'b0, x} + {1'b0, P}) >> 1);
      else
         return x >> 1;
   endfunction

   mod_sub_p u_sub_x1 (.x(x1), .y(x2), .d(x1_sub));
   mod_sub_p u_sub_x2 (.x(x2), .y(x1), .d(x2_sub));

   // The operand is < 2^256 < 2P, so one conditional subtract fully reduces it.
   assign u_red = (u >= P) ? (u - P) : u;
   assign busy  = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      u_nxt      = u;
      v_nxt      = v;
      x1_nxt     = x1;
      x2_nxt     = x2;
      result_nxt = result;
      done_nxt   = done;
      err_nxt    = err;
      case (state)
         IDLE: begin
            if (start) begin
               u_nxt     = a;
               done_nxt  = 1'b0;
               err_nxt   = 1'b0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            u_nxt  = u_red;
            v_nxt  = P;
            x1_nxt = 256'd1;
            x2_nxt = '0;
            if (u_red == '0) begin
               result_nxt = '0;
               err_nxt    = 1'b1;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end else begin
               state_nxt  = ITER;
            end
         end
         ITER: begin
            if (u == 256'd1) begin
               result_nxt = x1;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end else if (v == 256'd1) begin
               result_nxt = x2;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end else if (!u[0]) begin
               u_nxt  = u >> 1;
               x1_nxt = halve(x1);
            end else if (!v[0]) begin
               v_nxt  = v >> 1;
               x2_nxt = halve(x2);
            end else if (u >= v) begin
               u_nxt  = u - v;
               x1_nxt = x1_sub;
            end else begin
               v_nxt  = v - u;
               x2_nxt = x2_sub;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         u      <= '0;
         v      <= '0;
         x1     <= '0;
         x2     <= '0;
         result <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         u      <= u_nxt;
         v      <= v_nxt;
         x1     <= x1_nxt;
         x2     <= x2_nxt;
         result <= result_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mod_inv.sv
// Directed and random checks of mod_inv against a Fermat-exponentiation reference model.
// Expected results are queued at start and popped when done is observed.
module tb_mod_inv;
   import secp256k1_pkg::*;

   logic         clk;
   logic         rst;
   logic         start;
   logic [255:0] a;
   logic [255:0] result;
   logic         done;
   logic         busy;
   logic         err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [255:0] res;
      logic         err;
   } exp_t;

   exp_t sb[$];

   mod_inv dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .result (result),
      .done   (done),
      .busy   (busy),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
      logic [511:0] prod;
      prod = {256'b0, x} * {256'b0, y};
      return 256'(prod % {256'b0, P});
   endfunction

   // a^(P-2) mod P, independent of the Euclidean algorithm in the design.
   function automatic logic [255:0] inv_model(input logic [255:0] x);
      logic [255:0] r;
      logic [255:0] e;
      r = 256'd1;
      e = P - 256'd2;
      for (int i = 255; i >= 0; i--) begin
         r = mulmod(r, r);
         if (e[i]) r = mulmod(r, x);
      end
      return r;
   endfunction

   function automatic logic [255:0] rand_field();
      logic [255:0] r;
      r = '0;
      while (r == '0 || r >= P) begin
         for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      end
      return r;
   endfunction

   // Returns at the negedge following the accepting edge E0.
   task automatic start_op(input logic [255:0] val, input logic [255:0] exp_res, input logic exp_err);
      exp_t e;
      e.res = exp_res;
      e.err = exp_err;
      sb.push_back(e);
      @(negedge clk);
      a     = val;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_op(input string tag, output int lat);
      exp_t e;
      lat = 0;
      while (!done && lat < 1031) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_done"}, 256'(done), 256'd1);
      check({tag, "_lat_bound"}, 256'(lat <= 1030), 256'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_result"}, result, e.res);
         check({tag, "_err"}, 256'(err), 256'(e.err));
      end
   endtask

   initial begin
      int           lat;
      int           seen_done;
      logic [255:0] r;
      logic [256:0] t2;
      logic [257:0] t3;
      logic [255:0] half_p1;
      logic [255:0] third;

      t2      = {1'b0, P} + 257'd1;
      half_p1 = t2[256:1];
      t3      = ({2'b0, P} << 1) + 258'd1;
      t3      = t3 / 258'd3;
      third   = t3[255:0];

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      repeat (3) @(negedge clk);
      check("rst_result", result, '0);
      check("rst_done", 256'(done), '0);
      check("rst_busy", 256'(busy), '0);
      check("rst_err", 256'(err), '0);
      rst = 1'b0;

      start_op(256'd1, 256'd1, 1'b0);
      check("a1_busy", 256'(busy), 256'd1);
      finish_op("a1", lat);
      check("a1_latency", 256'(lat), 256'd2);

      start_op(P + 256'd1, 256'd1, 1'b0);
      finish_op("ap1", lat);
      check("ap1_latency", 256'(lat), 256'd2);

      start_op(256'd2, half_p1, 1'b0);
      finish_op("a2", lat);

      start_op(P - 256'd1, P - 256'd1, 1'b0);
      finish_op("apm1", lat);

      start_op(256'd0, '0, 1'b1);
      finish_op("a0", lat);
      check("a0_latency", 256'(lat), 256'd1);
      check("a0_busy_after", 256'(busy), '0);

      start_op(P, '0, 1'b1);
      finish_op("aP", lat);
      check("aP_latency", 256'(lat), 256'd1);
      repeat (5) @(negedge clk);
      check("aP_done_held", 256'(done), 256'd1);
      check("aP_err_held", 256'(err), 256'd1);

      for (int n = 0; n < 30; n++) begin
         r = rand_field();
         start_op(r, inv_model(r), 1'b0);
         finish_op("rand", lat);
         check("rand_product", mulmod(r, result), 256'd1);
      end

      r = rand_field();
      start_op(r, inv_model(r), 1'b0);
      repeat (3) @(negedge clk);
      a     = 256'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", 256'(busy), 256'd1);
      finish_op("ign", lat);
      repeat (4) @(negedge clk);
      check("ign_done_held", 256'(done), 256'd1);

      r = rand_field();
      @(negedge clk);
      a     = r;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("next_start_clears_done", 256'(done), '0);
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_result", result, '0);
      check("midrst_done", 256'(done), '0);
      check("midrst_busy", 256'(busy), '0);
      check("midrst_err", 256'(err), '0);
      rst = 1'b0;
      seen_done = 0;
      for (int c = 0; c < 1100; c++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      check("midrst_no_done", 256'(seen_done), '0);

      start_op(256'd3, third, 1'b0);
      finish_op("a3", lat);
      check("a3_product", mulmod(256'd3, result), 256'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
